// File: rtl/duc_rate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : duc_rate_pkg
// Description : Shared types and constants for the DUC rate controller.
//               Holds the controller state encoding and the error codes
//               reported on err_code.
// Revision    : 1.0 - initial release
// ============================================================================
package duc_rate_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FACTOR    = 3'd1,
        ST_CHECK     = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_WR_M      = 3'd4,
        ST_WR_INTERP = 3'd5,
        ST_DONE      = 3'd6,
        ST_ERR       = 3'd7
    } state_t;

    localparam logic [1:0] c_ERR_NONE = 2'd0;
    localparam logic [1:0] c_ERR_ZERO = 2'd1;
    localparam logic [1:0] c_ERR_CIC  = 2'd2;

endpackage : duc_rate_pkg
`default_nettype wire

// File: rtl/duc_rate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : duc_rate_ctrl
// Description : Splits a requested total interpolation rate into a number of
//               halfband stages (factors of two) plus a residual CIC rate,
//               pauses the upstream sample flow, waits for the datapath to
//               drain, then programs the DUC over the settings bus.
//
// Ports
//   clk                 : single clock
//   rst                 : synchronous active-high reset
//   req_rate[15:0]      : requested total interpolation rate
//   req_valid/req_ready : request handshake (ready only while idle)
//   dp_idle             : datapath holds no in-flight samples
//   dp_hold             : pause upstream sample flow
//   set_stb/addr/data   : settings-bus write (addr/data zero when no strobe)
//   done_stb            : request applied (one-cycle pulse)
//   err_stb/err_code    : request rejected (pulse) / reason (held)
// Revision    : 1.0 - initial release
// ============================================================================
module duc_rate_ctrl
    import duc_rate_pkg::*;
#(
    parameter int          NUM_HB         = 3,
    parameter int          CIC_MAX_INTERP = 128,
    parameter logic [7:0]  SR_M_ADDR      = 8'd0,
    parameter logic [7:0]  SR_INTERP_ADDR = 8'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req_rate,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        dp_idle,
    output logic        dp_hold,
    output logic        set_stb,
    output logic [7:0]  set_addr,
    output logic [31:0] set_data,
    output logic        done_stb,
    output logic        err_stb,
    output logic [1:0]  err_code
);

    localparam logic [7:0]  c_NUM_HB  = 8'(NUM_HB);
    localparam logic [15:0] c_CIC_MAX = 16'(CIC_MAX_INTERP);

    state_t      r_state;
    logic [15:0] r_rate;   // request as accepted, written verbatim as M
    logic [15:0] r_rem;    // residual rate left for the CIC
    logic [7:0]  r_hb;     // halfband stages consumed

    // All outputs are registered: each is loaded on the transition into the
    // state that owns it, so it is valid for exactly the cycles spent there.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_rate    <= 16'd0;
            r_rem     <= 16'd0;
            r_hb      <= 8'd0;
            req_ready <= 1'b1;
            dp_hold   <= 1'b0;
            set_stb   <= 1'b0;
            set_addr  <= 8'd0;
            set_data  <= 32'd0;
            done_stb  <= 1'b0;
            err_stb   <= 1'b0;
            err_code  <= c_ERR_NONE;
        end else begin
            set_stb  <= 1'b0;
            set_addr <= 8'd0;
            set_data <= 32'd0;
            done_stb <= 1'b0;
            err_stb  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        r_rate    <= req_rate;
                        r_rem     <= req_rate;
                        r_hb      <= 8'd0;
                        err_code  <= c_ERR_NONE;
                        req_ready <= 1'b0;
                        r_state   <= ST_FACTOR;
                    end
                end

                // Peel off one factor of two per cycle while halfbands remain.
                ST_FACTOR: begin
                    if ((r_rem != 16'd0) && !r_rem[0] && (r_hb < c_NUM_HB)) begin
                        r_rem <= r_rem >> 1;
                        r_hb  <= r_hb + 8'd1;
                    end else begin
                        r_state <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    if (r_rem == 16'd0) begin
                        err_code <= c_ERR_ZERO;
                        err_stb  <= 1'b1;
                        r_state  <= ST_ERR;
                    end else if (r_rem > c_CIC_MAX) begin
                        err_code <= c_ERR_CIC;
                        err_stb  <= 1'b1;
                        r_state  <= ST_ERR;
                    end else begin
                        dp_hold <= 1'b1;
                        r_state <= ST_DRAIN;
                    end
                end

                // Wait indefinitely; the datapath must empty before retuning.
                ST_DRAIN: begin
                    if (dp_idle) begin
                        set_stb  <= 1'b1;
                        set_addr <= SR_M_ADDR;
                        set_data <= {16'd0, r_rate};
                        r_state  <= ST_WR_M;
                    end
                end

                ST_WR_M: begin
                    set_stb  <= 1'b1;
                    set_addr <= SR_INTERP_ADDR;
                    set_data <= {16'd0, r_hb, r_rem[7:0]};
                    r_state  <= ST_WR_INTERP;
                end

                ST_WR_INTERP: begin
                    done_stb <= 1'b1;
                    r_state  <= ST_DONE;
                end

                ST_DONE: begin
                    dp_hold   <= 1'b0;
                    req_ready <= 1'b1;
                    r_state   <= ST_IDLE;
                end

                ST_ERR: begin
                    req_ready <= 1'b1;
                    r_state   <= ST_IDLE;
                end

                default: begin
                    dp_hold   <= 1'b0;
                    req_ready <= 1'b1;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : duc_rate_ctrl
`default_nettype wire

// File: tb/tb_duc_rate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_duc_rate_ctrl
// Description : Self-checking bench for duc_rate_ctrl. Expected settings
//               writes, done and error events are queued when a request is
//               driven and compared as the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_duc_rate_ctrl;

    localparam int         c_NUM_HB    = 3;
    localparam int         c_CIC_MAX   = 128;
    localparam logic [7:0] c_M_ADDR    = 8'd0;
    localparam logic [7:0] c_INTERP_AD = 8'd1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req_rate = 16'd0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        dp_idle = 1'b1;
    logic        dp_hold;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic        done_stb;
    logic        err_stb;
    logic [1:0]  err_code;

    duc_rate_ctrl #(
        .NUM_HB         (c_NUM_HB),
        .CIC_MAX_INTERP (c_CIC_MAX),
        .SR_M_ADDR      (c_M_ADDR),
        .SR_INTERP_ADDR (c_INTERP_AD)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_rate  (req_rate),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .dp_idle   (dp_idle),
        .dp_hold   (dp_hold),
        .set_stb   (set_stb),
        .set_addr  (set_addr),
        .set_data  (set_data),
        .done_stb  (done_stb),
        .err_stb   (err_stb),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    // kind: 0 = settings write, 1 = done, 2 = error
    typedef struct {
        int          kind;
        logic [7:0]  addr;
        logic [31:0] data;
        int          lat;   // -1: latency not checked
    } sb_item_t;

    sb_item_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int accept_cyc = 0;
    bit no_hold = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference split of a rate into halfband count and CIC remainder.
    task automatic model(input logic [15:0] rate, output int hb, output int rem);
        rem = int'(rate);
        hb  = 0;
        while (rem != 0 && (rem % 2) == 0 && hb < c_NUM_HB) begin
            rem = rem / 2;
            hb  = hb + 1;
        end
    endtask

    task automatic send(input logic [15:0] rate, input bit chk_lat);
        int hb, rem, n;
        sb_item_t it;
        model(rate, hb, rem);
        if (rem == 0 || rem > c_CIC_MAX) begin
            it.kind = 2; it.addr = 8'd0; it.lat = -1;
            it.data = (rem == 0) ? 32'd1 : 32'd2;
            sb.push_back(it);
            no_hold = 1'b1;
        end else begin
            it.kind = 0; it.addr = c_M_ADDR; it.data = {16'd0, rate}; it.lat = -1;
            sb.push_back(it);
            it.addr = c_INTERP_AD;
            it.data = 32'((hb << 8) | rem);
            sb.push_back(it);
            it.kind = 1; it.addr = 8'd0; it.data = 32'd0;
            it.lat = chk_lat ? hb + 5 : -1;
            sb.push_back(it);
        end
        @(negedge clk);
        req_rate  = rate;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("accept_timeout", 32'd1, 32'd0);
        accept_cyc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check("sb_drain", sb.size(), 0);
        repeat (2) @(negedge clk);
        no_hold = 1'b0;
    endtask

    sb_item_t m_it;
    always @(negedge clk) begin
        if (!rst) begin
            if (set_stb) begin
                if (sb.size() == 0) check("unexp_write", {24'd0, set_addr}, 32'hFFFF_FFFF);
                else begin
                    m_it = sb.pop_front();
                    check("wr_kind", 0, m_it.kind);
                    check("wr_addr", {24'd0, set_addr}, {24'd0, m_it.addr});
                    check("wr_data", set_data, m_it.data);
                end
            end else begin
                check("idle_bus", {set_addr, set_data[23:0]} | {8'd0, set_data[31:24]}, 32'd0);
            end
            if (done_stb) begin
                if (sb.size() == 0) check("unexp_done", 32'd1, 32'd0);
                else begin
                    m_it = sb.pop_front();
                    check("done_kind", 1, m_it.kind);
                    if (m_it.lat >= 0) check("latency", cyc - accept_cyc - 1, m_it.lat);
                end
            end
            if (err_stb) begin
                if (sb.size() == 0) check("unexp_err", 32'd1, 32'd0);
                else begin
                    m_it = sb.pop_front();
                    check("err_kind", 2, m_it.kind);
                    check("err_code", {30'd0, err_code}, m_it.data);
                end
            end
            if (no_hold) check("err_hold", {31'd0, dp_hold}, 32'd0);
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        // Reset state
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_outs", {26'd0, dp_hold, set_stb, done_stb, err_stb, err_code}, 32'd0);

        send(16'd40, 1'b1);   wait_done();
        send(16'd13, 1'b1);   wait_done();
        send(16'd0, 1'b0);    wait_done();
        repeat (3) @(negedge clk);
        check("err_code_hold", {30'd0, err_code}, 32'd1);
        send(16'd2048, 1'b0); wait_done();
        check("err_code_hold2", {30'd0, err_code}, 32'd2);
        send(16'd1000, 1'b1);
        check("err_code_clear", {30'd0, err_code}, 32'd0);
        wait_done();

        // Drain: datapath busy for 20 cycles after hold asserts
        dp_idle = 1'b0;
        send(16'd12, 1'b0);
        for (int i = 0; i < 20 && !dp_hold; i++) @(negedge clk);
        check("drain_hold_rise", {31'd0, dp_hold}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!dp_hold || set_stb) check("drain_wait", {30'd0, dp_hold, set_stb}, 32'd2);
        end
        dp_idle = 1'b1;
        wait_done();

        // Reset while draining aborts without writes
        dp_idle = 1'b0;
        send(16'd12, 1'b0);
        for (int i = 0; i < 20 && !dp_hold; i++) @(negedge clk);
        check("rst_drain_hold", {31'd0, dp_hold}, 32'd1);
        sb.delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        check("abort_outs", {26'd0, dp_hold, set_stb, done_stb, err_stb, err_code}, 32'd0);
        dp_idle = 1'b1;
        repeat (10) @(negedge clk);
        send(16'd4, 1'b1);    wait_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule : tb_duc_rate_ctrl
`default_nettype wire
